fun_sched: RTL and testbench

FUN_SCHED -- requirements
Module: fun_sched

---
 rtl/fun_sched.sv | 116 +++++++++++
 tb/tb_fun_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fun_sched.sv
// Two-requester front end for a shared multi-cycle arithmetic unit: round-robin
// grant, start/busy handshake, per-requester result registers and timeout recovery.
module fun_sched #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] a0_bi,
  input  logic [WIDTH-1:0] b0_bi,
  input  logic [WIDTH-1:0] a1_bi,
  input  logic [WIDTH-1:0] b1_bi,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic             err0_o,
  output logic             err1_o,
  output logic [WIDTH-1:0] y0_bo,
  output logic [WIDTH-1:0] y1_bo,
  output logic             u_start_o,
  output logic [WIDTH-1:0] u_a_bo,
  output logic [WIDTH-1:0] u_b_bo,
  input  logic             u_busy_i,
  input  logic [WIDTH-1:0] u_y_bi
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t        state;
  logic          ptr;
  logic          idx;
  logic          grant;
  logic          finish_ok;
  logic          finish_to;
  logic [CW-1:0] cnt;

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    grant     = (req0_i && req1_i) ? ptr : req1_i;
    finish_ok = (state == WAIT_DONE) && !u_busy_i;
    // A real result arriving on the timeout edge wins over the timeout.
    finish_to = !finish_ok && (state == WAIT_BUSY || state == WAIT_DONE) &&
                (cnt >= CW'(TIMEOUT - 1));
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      idx       <= 1'b0;
      cnt       <= '0;
      ack0_o    <= 1'b0;
      ack1_o    <= 1'b0;
      done0_o   <= 1'b0;
      done1_o   <= 1'b0;
      err0_o    <= 1'b0;
      err1_o    <= 1'b0;
      u_start_o <= 1'b0;
      u_a_bo    <= '0;
      u_b_bo    <= '0;
      y0_bo     <= '0;
      y1_bo     <= '0;
    end else begin
      ack0_o    <= 1'b0;
      ack1_o    <= 1'b0;
      done0_o   <= 1'b0;
      done1_o   <= 1'b0;
      err0_o    <= 1'b0;
      err1_o    <= 1'b0;
      u_start_o <= 1'b0;
      case (state)
        IDLE: begin
          // The busy gate keeps a unit still running after a timeout from being restarted.
          if ((req0_i || req1_i) && !u_busy_i) begin
            state     <= ISSUE;
            idx       <= grant;
            ptr       <= !grant;
            cnt       <= '0;
            u_a_bo    <= grant ? a1_bi : a0_bi;
            u_b_bo    <= grant ? b1_bi : b0_bi;
            ack0_o    <= !grant;
            ack1_o    <= grant;
            u_start_o <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          cnt   <= cnt + 1'b1;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (finish_ok || finish_to) begin
            state   <= DONE;
            done0_o <= !idx;
            done1_o <= idx;
            err0_o  <= finish_to && !idx;
            err1_o  <= finish_to && idx;
            if (idx) y1_bo <= finish_ok ? u_y_bi : '0;
            else     y0_bo <= finish_ok ? u_y_bi : '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == WAIT_BUSY && u_busy_i) state <= WAIT_DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fun_sched.sv
// Randomised self-checking bench for fun_sched: a behavioural subtract unit with
// programmable latency plus a transaction-level arbitration/latency model.
module tb_fun_sched;

  localparam int W  = 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, done0, done1, err0, err1, u_start;
  logic [W-1:0] y0, y1, u_a, u_b;
  logic         u_busy = 1'b0;
  logic [W-1:0] u_y = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  fun_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .a0_bi(a0), .b0_bi(b0), .a1_bi(a1), .b1_bi(b1),
    .ack0_o(ack0), .ack1_o(ack1), .done0_o(done0), .done1_o(done1),
    .err0_o(err0), .err1_o(err1), .y0_bo(y0), .y1_bo(y1),
    .u_start_o(u_start), .u_a_bo(u_a), .u_b_bo(u_b),
    .u_busy_i(u_busy), .u_y_bi(u_y)
  );

  // Behavioural unit: busy for unit_lat cycles after a start, result a - b.
  int           unit_lat  = 5;
  bit           unit_dead = 1'b0;
  int           busy_left = 0;
  logic [W-1:0] unit_res  = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_busy) begin
      if (busy_left <= 1) begin
        u_busy <= 1'b0;
        u_y    <= unit_res;
      end
      busy_left <= busy_left - 1;
    end else if (u_start && !unit_dead) begin
      u_busy    <= 1'b1;
      busy_left <= unit_lat;
      unit_res  <= u_a - u_b;
      u_y       <= W'($urandom);
    end
  end

  // Invariant monitors, sampled away from the active edge.
  int n_ack_both = 0, n_done_both = 0, n_start_bad = 0, n_err_bad = 0;
  always @(negedge clk) begin
    if (ack0 && ack1)                          n_ack_both  <= n_ack_both + 1;
    if (done0 && done1)                        n_done_both <= n_done_both + 1;
    if (u_start !== (ack0 | ack1))             n_start_bad <= n_start_bad + 1;
    if ((err0 && !done0) || (err1 && !done1))  n_err_bad   <= n_err_bad + 1;
  end

  // Reference model state: round-robin pointer and per-requester held results.
  int           ptr_m = 0;
  logic [W-1:0] y_m [2];
  bit           pend [2];
  logic [W-1:0] ma [2], mb [2];

  function automatic int arb(bit r0, bit r1, int p);
    if (r0 && r1) return p;
    return r1 ? 1 : 0;
  endfunction

  function automatic int exp_lat(int l);
    return (l + 2 > TO) ? TO : l + 2;
  endfunction

  task automatic drive_reqs();
    req0 = pend[0]; a0 = ma[0]; b0 = mb[0];
    req1 = pend[1]; a1 = ma[1]; b1 = mb[1];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0; y_m[0] = '0; y_m[1] = '0; pend[0] = 0; pend[1] = 0;
  endtask

  task automatic wait_ack(input int limit, output int idx, output int at,
                          output logic [W-1:0] ua, output logic [W-1:0] ub);
    idx = -1; at = -1; ua = '0; ub = '0;
    for (int i = 0; i < limit && idx < 0; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        idx = ack1 ? 1 : 0; at = cyc; ua = u_a; ub = u_b;
      end
    end
  endtask

  task automatic wait_done(input int limit, output int idx, output int at,
                           output logic [W-1:0] y, output logic err,
                           output logic [W-1:0] ua, output logic [W-1:0] ub);
    idx = -1; at = -1; y = '0; err = 1'b0; ua = '0; ub = '0;
    for (int i = 0; i < limit && idx < 0; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        idx = done1 ? 1 : 0; at = cyc; y = done1 ? y1 : y0;
        err = err0 | err1; ua = u_a; ub = u_b;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ack0, ack1, done0, done1, err0, err1, u_start, u_a, u_b, y0, y1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want all zero",
               {ack0, ack1, done0, done1, err0, err1, u_start, u_a, u_b, y0, y1});
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single();
    int idx, at, dat, rc; logic [W-1:0] ua, ub, y; logic err;
    do_reset();
    a0 = 23; b0 = 8; req0 = 1'b1; rc = cyc;
    wait_ack(10, idx, at, ua, ub);
    req0 = 1'b0;
    n_checks++;
    if (idx !== 0 || at - rc !== 1) begin
      n_fail++; $display("FAIL single_ack: idx=%0d lat=%0d, want idx=0 lat=1", idx, at - rc);
    end
    n_checks++;
    if (ua !== 8'd23 || ub !== 8'd8) begin
      n_fail++; $display("FAIL single_operands: a=%0d b=%0d, want 23 8", ua, ub);
    end
    wait_done(30, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 0 || dat - at !== 7) begin
      n_fail++; $display("FAIL single_done: idx=%0d lat=%0d, want idx=0 lat=7", idx, dat - at);
    end
    n_checks++;
    if (y !== 8'd15 || err !== 1'b0) begin
      n_fail++; $display("FAIL single_result: y=%0d err=%0b, want 15 0", y, err);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (y0 !== 8'd15) begin
      n_fail++; $display("FAIL single_hold: y0=%0d, want 15", y0);
    end
  endtask

  task automatic test_simultaneous();
    int idx, at, dat, at1, dat1; logic [W-1:0] ua, ub, y; logic err;
    do_reset();
    a0 = 50; b0 = 20; a1 = 9; b1 = 4; req0 = 1'b1; req1 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req0 = 1'b0;
    n_checks++;
    if (idx !== 0) begin n_fail++; $display("FAIL simul_first: idx=%0d, want 0", idx); end
    wait_done(30, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 0 || y !== 8'd30 || err !== 1'b0) begin
      n_fail++; $display("FAIL simul_y0: idx=%0d y=%0d err=%0b, want 0 30 0", idx, y, err);
    end
    wait_ack(10, idx, at1, ua, ub);
    req1 = 1'b0;
    n_checks++;
    if (idx !== 1 || at1 - dat !== 2) begin
      n_fail++; $display("FAIL simul_second: idx=%0d gap=%0d, want 1 2", idx, at1 - dat);
    end
    wait_done(30, idx, dat1, y, err, ua, ub);
    n_checks++;
    if (idx !== 1 || y !== 8'd5 || y0 !== 8'd30) begin
      n_fail++; $display("FAIL simul_y1: idx=%0d y1=%0d y0=%0d, want 1 5 30", idx, y, y0);
    end
  endtask

  task automatic test_fairness();
    int idx, at, dat, wexp; logic [W-1:0] ua, ub, y, ea, eb; logic err;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1; ma[r] = W'($urandom); mb[r] = W'($urandom);
    end
    drive_reqs();
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, idx, at, ua, ub);
      wexp = arb(pend[0], pend[1], ptr_m);
      ptr_m = 1 - wexp;
      ea = ma[wexp]; eb = mb[wexp];
      n_checks++;
      if (idx !== wexp || ua !== ea || ub !== eb) begin
        n_fail++;
        $display("FAIL fair_grant%0d: idx=%0d a=%0d b=%0d, want %0d %0d %0d", k, idx, ua, ub, wexp, ea, eb);
      end
      ma[wexp] = W'($urandom); mb[wexp] = W'($urandom);
      if (k == 3) begin pend[0] = 0; pend[1] = 0; end
      drive_reqs();
      wait_done(30, idx, dat, y, err, ua, ub);
      n_checks++;
      if (idx !== wexp || y !== W'(ea - eb) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_done%0d: idx=%0d y=%0d err=%0b, want %0d %0d 0", k, idx, y, err, wexp, W'(ea - eb));
      end
    end
  endtask

  task automatic test_timeout();
    int idx, at, dat; logic [W-1:0] ua, ub, y, ea, eb; logic err;
    do_reset();
    a0 = 100; b0 = 1; req0 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req0 = 1'b0;
    wait_done(30, idx, dat, y, err, ua, ub);
    unit_dead = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req0 = 1'b0;
    wait_done(TO + 20, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 0 || dat - at !== TO || err !== 1'b1 || y0 !== '0) begin
      n_fail++;
      $display("FAIL timeout_dead: idx=%0d lat=%0d err=%0b y0=%0d, want 0 %0d 1 0", idx, dat - at, err, y0, TO);
    end
    unit_dead = 1'b0;
    ea = W'($urandom); eb = W'($urandom);
    a1 = ea; b1 = eb; req1 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req1 = 1'b0;
    wait_done(30, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 1 || dat - at !== 7 || err !== 1'b0 || y !== W'(ea - eb)) begin
      n_fail++;
      $display("FAIL timeout_recover: idx=%0d lat=%0d err=%0b y=%0d, want 1 7 0 %0d", idx, dat - at, err, y, W'(ea - eb));
    end
    // Latencies straddling the timeout boundary.
    for (int l = TO - 2; l <= TO - 1; l++) begin
      unit_lat = l;
      ea = W'($urandom); eb = W'($urandom);
      a0 = ea; b0 = eb; req0 = 1'b1;
      wait_ack(10, idx, at, ua, ub);
      req0 = 1'b0;
      wait_done(TO + 20, idx, dat, y, err, ua, ub);
      n_checks++;
      if (idx !== 0 || dat - at !== exp_lat(l) || err !== (l + 2 > TO) ||
          y !== ((l + 2 > TO) ? W'(0) : W'(ea - eb))) begin
        n_fail++;
        $display("FAIL timeout_edge_L%0d: lat=%0d err=%0b y=%0d, want %0d %0b", l, dat - at, err, y, exp_lat(l), (l + 2 > TO));
      end
      repeat (3) @(negedge clk);
    end
    unit_lat = 5;
  endtask

  task automatic test_busy_gate();
    int idx, at, at0, dat; logic [W-1:0] ua, ub, y, ea, eb; logic err;
    do_reset();
    unit_lat = 80;
    a1 = W'($urandom); b1 = W'($urandom); req1 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req1 = 1'b0;
    wait_done(TO + 20, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 1 || err !== 1'b1 || dat - at !== TO) begin
      n_fail++; $display("FAIL gate_timeout: idx=%0d err=%0b lat=%0d, want 1 1 %0d", idx, err, dat - at, TO);
    end
    unit_lat = 5;
    ea = W'($urandom); eb = W'($urandom);
    a0 = ea; b0 = eb; req0 = 1'b1;
    wait_ack(60, idx, at0, ua, ub);
    req0 = 1'b0;
    n_checks++;
    if (idx !== 0 || at0 - at !== 80 + 2) begin
      n_fail++; $display("FAIL gate_hold: idx=%0d gap=%0d, want 0 %0d", idx, at0 - at, 82);
    end
    wait_done(30, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 0 || y !== W'(ea - eb) || err !== 1'b0) begin
      n_fail++; $display("FAIL gate_after: idx=%0d y=%0d err=%0b, want 0 %0d 0", idx, y, err, W'(ea - eb));
    end
  endtask

  task automatic test_reset_mid();
    int idx, at, dat, n_done; logic [W-1:0] ua, ub, y; logic err;
    do_reset();
    a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
    wait_ack(10, idx, at, ua, ub);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ack0, ack1, done0, done1, err0, err1, u_start, u_a, u_b, y0, y1} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, want all zero",
               {ack0, ack1, done0, done1, err0, err1, u_start, u_a, u_b, y0, y1});
    end
    rst = 1'b0; ptr_m = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 || done1) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL midreset_nodone: dones=%0d, want 0", n_done); end
    a1 = 7; b1 = 7; req1 = 1'b1;
    wait_ack(20, idx, at, ua, ub);
    req1 = 1'b0;
    wait_done(30, idx, dat, y, err, ua, ub);
    n_checks++;
    if (idx !== 1 || y !== '0 || err !== 1'b0 || y0 !== '0) begin
      n_fail++; $display("FAIL midreset_after: idx=%0d y1=%0d err=%0b y0=%0d, want 1 0 0 0", idx, y, err, y0);
    end
  endtask

  task automatic test_random();
    int idx, at, dat, rc, wexp, last_done, lat; logic [W-1:0] ua, ub, y, ea, eb; logic err;
    do_reset();
    last_done = -1;
    for (int it = 0; it < 24; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1; ma[r] = W'($urandom); mb[r] = W'($urandom);
        end
      if (!pend[0] && !pend[1]) begin
        rc = $urandom_range(0, 1);
        pend[rc] = 1; ma[rc] = W'($urandom); mb[rc] = W'($urandom);
      end
      lat = $urandom_range(1, 8);
      unit_lat = lat;
      drive_reqs();
      rc = cyc;
      wait_ack(20, idx, at, ua, ub);
      wexp = arb(pend[0], pend[1], ptr_m);
      ptr_m = 1 - wexp;
      ea = ma[wexp]; eb = mb[wexp];
      pend[wexp] = 0;
      drive_reqs();
      n_checks++;
      if (idx !== wexp || ua !== ea || ub !== eb ||
          at !== ((last_done < 0) ? rc + 1 : last_done + 2)) begin
        n_fail++;
        $display("FAIL rand_ack%0d: idx=%0d a=%0d b=%0d at=%0d, want %0d %0d %0d", it, idx, ua, ub, at, wexp, ea, eb,
                 (last_done < 0) ? rc + 1 : last_done + 2);
      end
      y_m[wexp] = W'(ea - eb);
      wait_done(30, idx, dat, y, err, ua, ub);
      n_checks++;
      if (idx !== wexp || dat - at !== exp_lat(lat) || err !== 1'b0 ||
          y0 !== y_m[0] || y1 !== y_m[1] || ua !== ea || ub !== eb) begin
        n_fail++;
        $display("FAIL rand_done%0d: idx=%0d lat=%0d err=%0b y0=%0d y1=%0d, want %0d %0d 0 %0d %0d",
                 it, idx, dat - at, err, y0, y1, wexp, exp_lat(lat), y_m[0], y_m[1]);
      end
      last_done = dat;
    end
    pend[0] = 0; pend[1] = 0;
    drive_reqs();
    unit_lat = 5;
  endtask

  task automatic test_invariants();
    n_checks++;
    if (n_ack_both !== 0 || n_done_both !== 0) begin
      n_fail++; $display("FAIL exclusive: ack_overlaps=%0d done_overlaps=%0d, want 0 0", n_ack_both, n_done_both);
    end
    n_checks++;
    if (n_start_bad !== 0 || n_err_bad !== 0) begin
      n_fail++; $display("FAIL pulse_pairing: start_vs_ack=%0d err_wo_done=%0d, want 0 0", n_start_bad, n_err_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_busy_gate();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
